// File: rtl/divider_arbiter_pkg.sv
// Shared types for the divider arbiter: sequencer states and default timing.
package divider_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4,
        RESP      = 3'd5
    } arb_state_t;

    localparam int BUSY_TIMEOUT_DEFAULT = 2;

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module divider_arbiter_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int pos;

    // Scan from the farthest slot to the nearest so the last hit wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        pos   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = int'(i_ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (i_req[pos]) begin
                o_idx = IDX_W'(pos);
                o_any = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign o_grant[gi] = o_any && (o_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end that time-shares one multi-cycle divider among N_REQ clients.
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int WIDTH        = 8,
    parameter  int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT,
    localparam int IDX_W        = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_cg,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*WIDTH-1:0] i_req_dividend,
    input  logic [N_REQ*WIDTH-1:0] i_req_divisor,
    output logic [N_REQ-1:0]       o_rsp_valid,
    input  logic [N_REQ-1:0]       i_rsp_ready,
    output logic [WIDTH-1:0]       o_rsp_quotient,
    output logic [WIDTH-1:0]       o_rsp_remainder,
    output logic                   o_div_begin,
    output logic [WIDTH-1:0]       o_div_dividend,
    output logic [WIDTH-1:0]       o_div_divisor,
    input  logic                   i_div_busy,
    input  logic [WIDTH-1:0]       i_div_quotient,
    input  logic [WIDTH-1:0]       i_div_remainder,
    output logic [IDX_W-1:0]       o_owner
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_begin_q, div_begin_d;
    logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
    logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [CNT_W-1:0] cnt_inc;

    divider_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (ptr_q),
        .o_grant (grant),
        .o_idx   (grant_idx),
        .o_any   (grant_any)
    );

    // Ready is withheld on gated or reset cycles, where an accept could not be registered.
    always_comb begin
        o_req_ready = '0;
        if (state_q == IDLE && i_cg && !i_rst && !i_div_busy && grant_any) begin
            o_req_ready = grant;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        owner_d         = owner_q;
        cnt_d           = cnt_q;
        div_begin_d     = 1'b0;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        case (state_q)
            IDLE: begin
                if (|o_req_ready) begin
                    div_dividend_d = i_req_dividend[grant_idx*WIDTH +: WIDTH];
                    div_divisor_d  = i_req_divisor[grant_idx*WIDTH +: WIDTH];
                    owner_d        = grant_idx;
                    ptr_d          = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    div_begin_d    = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A divider that finishes before busy is seen is treated as done after the timeout.
                if (i_div_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        state_d = CAPTURE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!i_div_busy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_quotient_d  = i_div_quotient;
                rsp_remainder_d = i_div_remainder;
                rsp_valid_d     = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
                state_d         = RESP;
            end
            RESP: begin
                if (i_rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            owner_q         <= '0;
            cnt_q           <= '0;
            div_begin_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
        end else if (i_cg) begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            owner_q         <= owner_d;
            cnt_q           <= cnt_d;
            div_begin_q     <= div_begin_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
        end
    end

    assign o_div_begin     = div_begin_q;
    assign o_div_dividend  = div_dividend_q;
    assign o_div_divisor   = div_divisor_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_quotient  = rsp_quotient_q;
    assign o_rsp_remainder = rsp_remainder_q;
    assign o_owner         = owner_q;

endmodule
